// File: rtl/vga_timing_pkg.sv
// Shared 1024x768@60 timing constants, counter width and lock-FSM state type
// used by the VGA sync generator and the receive-side sync detector.
package vga_timing_pkg;

    localparam int              CNT_W   = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam int H_PIXELS    = 1344;
    localparam int H_PULSE     = 136;
    localparam int V_LINES     = 806;
    localparam int V_PULSE     = 6;
    localparam int H_TOL_DEF   = 2;
    localparam int LOCK_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        LOCKED
    } det_state_e;

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/vga_pulse_meas.sv
// Edge detect plus period and low-width measurement of one active-low sync.
// Counters advance only on tick_i (every clock for hsync, every hfall for vsync).
module vga_pulse_meas
    import vga_timing_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             sync_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] pulse_o,
    output logic             fall_o
);

    logic             sync_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;

    always_comb begin
        fall_o   = sync_q & ~sync_i;
        rise     = ~sync_q & sync_i;
        cnt_d    = cnt_q;
        period_d = period_q;
        width_d  = width_q;
        pulse_d  = pulse_q;

        // A tick coinciding with the falling edge belongs to the period just ending
        if (fall_o) begin
            period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(tick_i);
            cnt_d    = '0;
            width_d  = CNT_W'(tick_i);
        end else if (tick_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!sync_i && !fall_o && tick_i && width_q != CNT_MAX) begin
            width_d = width_q + CNT_W'(1);
        end

        if (rise) begin
            pulse_d = width_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 1'b1;
            cnt_q    <= '0;
            period_q <= '0;
            width_q  <= '0;
            pulse_q  <= '0;
        end else begin
            sync_q   <= sync_i;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            width_q  <= width_d;
            pulse_q  <= pulse_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign period_o = period_q;
    assign pulse_o  = pulse_q;

endmodule

// File: rtl/vga_sync_detector.sv
// Receive-side VGA sync detector: rebuilds h/v counters, measures sync timing and
// locks once consecutive frames match. VGA_SYNC_DET_ERRCNT_EN adds err_cnt_o.
module vga_sync_detector
    import vga_timing_pkg::*;
#(
    parameter int EXP_H_PIXELS = H_PIXELS,
    parameter int EXP_H_PULSE  = H_PULSE,
    parameter int EXP_V_LINES  = V_LINES,
    parameter int EXP_V_PULSE  = V_PULSE,
    parameter int H_TOL        = H_TOL_DEF,
    parameter int LOCK_FRAMES  = LOCK_FRAMES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hsync_i,
    input  logic             vsync_i,
    output logic [CNT_W-1:0] hc_o,
    output logic [CNT_W-1:0] vc_o,
    output logic [CNT_W-1:0] h_period_o,
    output logic [CNT_W-1:0] h_pulse_o,
    output logic [CNT_W-1:0] v_period_o,
    output logic [CNT_W-1:0] v_pulse_o,
    output logic             frame_o,
    output logic             locked_o,
`ifdef VGA_SYNC_DET_ERRCNT_EN
    output logic [7:0]       err_cnt_o,
`endif
    output logic             lost_o
);

    logic             hfall, vfall;
    logic             wdog, match, eval;
    logic [CNT_W-1:0] v_period_new;
    det_state_e       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             frame_q, frame_d;
    logic             locked_q, locked_d;
    logic             lost_q, lost_d;

    vga_pulse_meas u_h_meas (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (1'b1),
        .sync_i   (hsync_i),
        .cnt_o    (hc_o),
        .period_o (h_period_o),
        .pulse_o  (h_pulse_o),
        .fall_o   (hfall)
    );

    vga_pulse_meas u_v_meas (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (hfall),
        .sync_i   (vsync_i),
        .cnt_o    (vc_o),
        .period_o (v_period_o),
        .pulse_o  (v_pulse_o),
        .fall_o   (vfall)
    );

    // Frame height as it is being latched this cycle, not the stale register
    assign v_period_new = (vc_o == CNT_MAX) ? CNT_MAX : vc_o + CNT_W'(hfall);

    always_comb begin
        wdog  = (hc_o == CNT_MAX) || (vc_o == CNT_MAX);
        match = (abs_diff(int'(h_period_o), EXP_H_PIXELS) <= H_TOL) &&
                (abs_diff(int'(h_pulse_o), EXP_H_PULSE) <= H_TOL) &&
                (int'(v_period_new) == EXP_V_LINES) &&
                (int'(v_pulse_o) == EXP_V_PULSE);
        eval  = vfall && !wdog && (state_q != IDLE);

        state_d = state_q;
        cnt_d   = cnt_q;

        if (wdog) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (vfall) begin
            unique case (state_q)
                IDLE: begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end
                CHECK: begin
                    if (!match) begin
                        cnt_d = '0;
                    end else if (int'(cnt_q) + 1 == LOCK_FRAMES) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        frame_d  = vfall;
        locked_d = (state_d == LOCKED);
        lost_d   = (state_q == LOCKED) && (state_d != LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            frame_q  <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign frame_o  = frame_q;
    assign locked_o = locked_q;
    assign lost_o   = lost_q;

`ifdef VGA_SYNC_DET_ERRCNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (eval && !match && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt_o = err_q;
`endif

endmodule

// File: tb/tb_vga_sync_detector.sv
// Directed bench for vga_sync_detector on a scaled-down raster (64 clk x 20 lines)
// so every lock/unlock/watchdog scenario fits in a short run.
module tb_vga_sync_detector;

    localparam int H  = 64;
    localparam int HP = 8;
    localparam int V  = 20;
    localparam int VP = 3;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic [10:0] hc_o, vc_o, h_period_o, h_pulse_o, v_period_o, v_pulse_o;
    logic        frame_o, locked_o, lost_o;
`ifdef VGA_SYNC_DET_ERRCNT_EN
    logic [7:0]  err_cnt_o;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int lost_cnt     = 0;
    int frame_cnt    = 0;

    vga_sync_detector #(
        .EXP_H_PIXELS (H),
        .EXP_H_PULSE  (HP),
        .EXP_V_LINES  (V),
        .EXP_V_PULSE  (VP)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .hc_o       (hc_o),
        .vc_o       (vc_o),
        .h_period_o (h_period_o),
        .h_pulse_o  (h_pulse_o),
        .v_period_o (v_period_o),
        .v_pulse_o  (v_pulse_o),
        .frame_o    (frame_o),
        .locked_o   (locked_o),
`ifdef VGA_SYNC_DET_ERRCNT_EN
        .err_cnt_o  (err_cnt_o),
`endif
        .lost_o     (lost_o)
    );

    always #5 clk = ~clk;

    // Count single-cycle pulses on the inactive edge
    always @(negedge clk) begin
        if (lost_o)  lost_cnt++;
        if (frame_o) frame_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n, input logic hs, input logic vs);
        hsync_i = hs;
        vsync_i = vs;
        repeat (n) step();
    endtask

    task automatic gen_frame(input int lines, input int len, input int hpw, input int vpw);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < len; x++) begin
                hsync_i = (x >= hpw);
                vsync_i = (y >= vpw);
                step();
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        repeat (3) step();
        check("rst_hc", int'(hc_o), 0);
        check("rst_h_period", int'(h_period_o), 0);
        check("rst_v_period", int'(v_period_o), 0);
        check("rst_locked", int'(locked_o), 0);
        check("rst_frame", int'(frame_o), 0);
        check("rst_lost", int'(lost_o), 0);
`ifdef VGA_SYNC_DET_ERRCNT_EN
        check("rst_err", int'(err_cnt_o), 0);
`endif

        rst_ni = 1'b1;
        hold(4, 1'b1, 1'b1);
        check("no_frame_on_release", frame_cnt, 0);

        // Nominal stream: vfall 1 arms, 2 counts, 3 locks
        gen_frame(V, H, HP, VP);
        gen_frame(V, H, HP, VP);
        check("locked_after_2_vfalls", int'(locked_o), 0);
        gen_frame(V, H, HP, VP);
        check("locked_after_3_vfalls", int'(locked_o), 1);
        check("h_period", int'(h_period_o), H);
        check("h_pulse", int'(h_pulse_o), HP);
        check("v_period_coinc", int'(v_period_o), V);
        check("v_pulse", int'(v_pulse_o), VP);
        check("hc_end_frame", int'(hc_o), H - 1);
        check("vc_end_frame", int'(vc_o), V - 1);
        check("frame_pulses", frame_cnt, 3);

        // Line period within tolerance keeps lock
        gen_frame(V, H + 1, HP, VP);
        gen_frame(V, H + 1, HP, VP);
        check("h_period_tol", int'(h_period_o), H + 1);
        check("locked_tol", int'(locked_o), 1);
        check("lost_none_tol", lost_cnt, 0);

        // Out-of-tolerance line period is judged at the following vfall
        gen_frame(V, H + 4, HP, VP);
        check("h_period_bad", int'(h_period_o), H + 4);
        check("locked_before_eval", int'(locked_o), 1);
        gen_frame(V, H, HP, VP);
        check("unlock_bad_line", int'(locked_o), 0);
        check("lost_once", lost_cnt, 1);
        gen_frame(V, H, HP, VP);
        check("relock_not_yet", int'(locked_o), 0);
        gen_frame(V, H, HP, VP);
        check("relock", int'(locked_o), 1);
        check("lost_still_once", lost_cnt, 1);

        // Watchdog: hsync stuck high
        hold(1900, 1'b1, 1'b1);
        check("wdog_hc_1963", int'(hc_o), H - 1 + 1900);
        check("wdog_locked_before", int'(locked_o), 1);
        hold(200, 1'b1, 1'b1);
        check("wdog_hc_sat", int'(hc_o), 2047);
        check("wdog_unlocked", int'(locked_o), 0);
        check("wdog_lost", lost_cnt, 2);
        check("wdog_keeps_h_period", int'(h_period_o), H);

        // First vfall coincides with hc=2047: watchdog wins, so one extra frame to lock
        gen_frame(V, H, HP, VP);
        gen_frame(V, H, HP, VP);
        gen_frame(V, H, HP, VP);
        check("wdog_wins_vfall", int'(locked_o), 0);
        gen_frame(V, H, HP, VP);
        check("relock_after_wdog", int'(locked_o), 1);

        // Asynchronous reset mid-line
        hold(20, 1'b1, 1'b1);
        check("locked_pre_rst", int'(locked_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_hc", int'(hc_o), 0);
        check("arst_vc", int'(vc_o), 0);
        check("arst_h_pulse", int'(h_pulse_o), 0);
        check("arst_v_pulse", int'(v_pulse_o), 0);
        check("arst_v_period", int'(v_period_o), 0);
        check("arst_locked", int'(locked_o), 0);
        step();
        rst_ni = 1'b1;
        hold(5, 1'b1, 1'b1);
        check("arst_no_frame", frame_cnt, 13);
        check("arst_no_lost", lost_cnt, 2);

        gen_frame(V, H, HP, VP);
        gen_frame(V, H, HP, VP);
        check("post_rst_arm_only", int'(locked_o), 0);
        gen_frame(V, H, HP, VP);
        check("post_rst_lock", int'(locked_o), 1);

`ifdef VGA_SYNC_DET_ERRCNT_EN
        check("err_zero_good", int'(err_cnt_o), 0);
        gen_frame(V, H, HP, VP - 1);
        gen_frame(V, H, HP, VP - 1);
        gen_frame(V, H, HP, VP - 1);
        gen_frame(V, H, HP, VP);
        check("err_three", int'(err_cnt_o), 3);
        repeat (300) gen_frame(4, 16, 2, 1);
        check("err_saturate", int'(err_cnt_o), 255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_sync_detector.md
# vga_sync_detector

Receive-side counterpart of the VGA sync generator. Samples active-low hsync/vsync, measures line period, hsync width, frame height and vsync width, and rebuilds horizontal/vertical counters. A lock FSM declares the incoming 1024x768@60 timing valid once consecutive frames match. It sits at the capture/loopback input, in the same 65 MHz domain as the generator.

## Interface
- EXP_H_PIXELS, 1344, expected clocks per line
- EXP_H_PULSE, 136, expected hsync low width (clocks)
- EXP_V_LINES, 806, expected lines per frame
- EXP_V_PULSE, 6, expected vsync low width (lines)
- H_TOL, 2, allowed ± deviation on horizontal measurements (clocks)
- LOCK_FRAMES, 2, consecutive matching frames required to lock
- clk_i  in  1  pixel clock, 65 MHz
- rst_ni  in  1  reset, asynchronous, active-low
- hsync_i  in  1  hsync, active-low, synchronous to clk_i
- vsync_i  in  1  vsync, active-low, synchronous to clk_i
- hc_o  out  11  clocks since last hsync fall
- vc_o  out  11  hsync falls since last vsync fall
- h_period_o  out  11  last measured line period (clocks)
- h_pulse_o  out  11  last measured hsync low width (clocks)
- v_period_o  out  11  last measured frame height (lines)
- v_pulse_o  out  11  last measured vsync low width (lines)
- frame_o  out  1  one-cycle pulse on vsync fall
- locked_o  out  1  timing matches expected
- lost_o  out  1  one-cycle pulse on leaving LOCKED

## Operation
- Registered copies hs_q, vs_q; hfall = hs_q & ~hsync_i, hrise = ~hs_q & hsync_i; same for vsync.
- Horizontal: on hfall, h_period_o <= hc+1, hc <= 0; else hc increments, saturating at 2047. Width counter set to 1 on hfall, +1 each further low cycle; on hrise, h_pulse_o <= width.
- Vertical: vc increments on every hfall. On vfall, v_period_o <= vc (+1 if hfall in the same cycle), vc <= 0. vsync width counts hfalls while vsync_i low (including a coincident hfall on vfall), latched into v_pulse_o on vrise.
- Match at vfall: |h_period_o−EXP_H_PIXELS| ≤ H_TOL, |h_pulse_o−EXP_H_PULSE| ≤ H_TOL, v period value being latched == EXP_V_LINES, v_pulse_o == EXP_V_PULSE.
- FSM IDLE: first vfall → CHECK, cnt=0, no evaluation (partial frame).
- FSM CHECK: vfall with match → cnt+1; cnt+1 == LOCK_FRAMES → LOCKED. Mismatch → cnt=0.
- FSM LOCKED: vfall mismatch → CHECK, cnt=0, lost_o pulse.
- Watchdog: hc or vc reaching 2047 → IDLE from any state. lost_o pulses if leaving LOCKED. Watchdog wins over a simultaneous vfall.
- Measurements are never cleared by the watchdog.

## Timing
- Reset: all counters/measurements 0, hs_q = vs_q = 1 (no false edge on release), state IDLE, locked_o = frame_o = lost_o = 0.
- All outputs registered. Measurements update one clock after the edge sample. frame_o is asserted in the cycle after vfall is sampled.
- locked_o rises and falls in the same cycle as the state register; lost_o is coincident with the locked_o fall.
- Reset mid-frame: immediate return to reset values. First post-reset vfall only arms CHECK.

## Configuration
- VGA_SYNC_DET_ERRCNT_EN defined: adds output err_cnt_o [7:0], a saturating count of mismatching frames evaluated in CHECK or LOCKED. Reset 0, held at 255.
- Undefined: port and counter absent. All other behaviour is identical.

## Structure
- Shared package vga_timing_pkg: CNT_W = 11, 1024x768@60 timing constants shared with the generator, and the FSM state enum (IDLE, CHECK, LOCKED).
- Sub-module vga_pulse_meas: edge detect plus period/low-width measurement with a tick-enable input. Instantiated twice: horizontal with enable = 1, vertical with enable = hfall. Top holds the FSM, watchdog and compare logic.

## Test plan
- Nominal generator stream after reset: h_period_o = 1344, h_pulse_o = 136, v_period_o = 806, v_pulse_o = 6. locked_o = 1 after the 3rd vfall.
- Line period 1345 while locked (H_TOL = 2): locked_o stays 1. Line period 1348: lost_o pulses once and the FSM re-locks two good frames later.
- hsync_i held high 2100 cycles while locked: IDLE at hc = 2047, lost_o pulse, locked_o = 0.
- vsync falling on the same cycle as hsync: v_period_o counts that line (806, not 805).
- rst_ni asserted mid-line while locked: all outputs 0 asynchronously. No frame_o on release with both syncs high.
- With VGA_SYNC_DET_ERRCNT_EN: 3 frames with vsync width 5 → err_cnt_o = 3. After 300 bad frames → err_cnt_o = 255.
